text_console_writer: RTL and testbench
======================================

# text_console_writer

Character-stream console front end that fills the text and colour memories scanned by the VGA text renderer. It accepts one character and colour per valid/ready handshake, tracks a cursor, and interprets a small set of control codes. Each accepted character becomes a single-cycle write into the shared text/colour RAM. Line advance and screen clear are multi-cycle RAM fills. It sits between the CPU's memory-mapped output port and the text RAM the renderer reads.

## Interface
- COLS, 79, characters per line (renderer line stride)
- ROWS, 12, visible lines; COLS*ROWS ≤ DEPTH
- DEPTH, 1000, text/colour RAM entries; ≤ 1024
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  character offered
- in_ready  out  1  block can accept this cycle
- in_char  in  8  ASCII code
- in_color  in  8  colour code (0 black, 1 blue, 2 green, other orange)
- wr_en  out  1  RAM write strobe
- wr_addr  out  10  RAM address = row*COLS + col
- wr_char  out  8  text RAM data
- wr_color  out  8  colour RAM data
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  4  current row, 0..ROWS-1
- busy  out  1  high in any clear state

## Operation
- Single clock; rst is asynchronous and active-high.
- States: CLEAR_ALL, IDLE, CLEAR_LINE. All outputs are registered.
- Reset values: state CLEAR_ALL, clear counter 0, cursor (0,0), wr_en 0, wr_addr 0, wr_char 0, wr_color 0, in_ready 0, busy 1.
- CLEAR_ALL:
  - Writes char 0 and colour 0 to addresses 0..DEPTH-1, one address per cycle, ascending.
  - Goes to IDLE after the write to DEPTH-1.
- CLEAR_LINE:
  - Writes zeros to addresses cursor_row*COLS .. cursor_row*COLS+COLS-1, ascending.
  - Goes to IDLE after the last write.
- IDLE: in_ready 1. A transfer is accepted when in_valid & in_ready. Actions by in_char:
  - 0x20..0x7E (printable):
    - Write {in_char, in_color} at the pre-update cursor.
    - col+1. If col was COLS-1: col 0, row advance.
  - 0x0A (newline): col 0, row advance. No character write.
  - 0x0D (carriage return): col 0. No write.
  - 0x08 (backspace):
    - If col>0: col-1, then write {0x00, 0x00} at the new position.
    - If col=0: no-op; the cursor never moves up a row.
  - 0x0C (form feed): cursor (0,0), enter CLEAR_ALL.
  - Any other code, including 0x00 and 0x7F: accepted and discarded. No write, cursor unchanged.
- Row advance:
  - row+1, wrapping from ROWS-1 to 0.
  - Always enters CLEAR_LINE for the new row. There is no scrolling.
- A new row is cleared before any character is placed in it.
- Address arithmetic: row*COLS+col computed 10 bits wide. Never exceeds COLS*ROWS-1.

## Timing
- Accept in cycle N → wr_en=1 with address/data in cycle N+1.
- Back-to-back accepts in IDLE with no row advance: one write per cycle, no bubbles.
- in_ready is 0 from cycle N+1 after any accept that causes a row advance or form feed. It stays 0 until the clear completes.
- Newline accepted at N:
  - Clear writes in N+1 .. N+COLS.
  - in_ready is 1 again at N+COLS+1.
- Printable that auto-wraps, accepted at N:
  - Character write in N+1.
  - Clear writes in N+2 .. N+COLS+1.
  - in_ready is 1 at N+COLS+2.
- Form feed accepted at N:
  - Clear writes in N+1 .. N+DEPTH.
  - in_ready is 1 at N+DEPTH+1.
- After reset release, the clear runs in the first DEPTH cycles. in_ready rises the next cycle.
- Cursor outputs update in cycle N+1. During a clear they already show the destination.
- wr_en is 0 in every cycle without a write. wr_addr, wr_char and wr_color hold their last values.
- in_valid while in_ready=0 is ignored. The source must hold the character.
- rst mid-clear or mid-stream: immediate return to the reset values. The full clear restarts from address 0.

## Test plan
- Release rst → wr_en=1 for 1000 cycles, addresses 0..999, data 0. in_ready=0 throughout, then 1. Cursor (0,0).
- Send 'A' (0x41) with colour 0x02 at (0,0) → next cycle wr_en, addr 0, wr_char 0x41, wr_color 0x02. Cursor (0,1).
- Send 'H','I',0x0A,'X' back-to-back → writes at addr 0, 1; clear of addr 79..157; 'X' written at addr 79. Cursor ends at row 1, col 1.
- Send 79 printables from (0,0) → last write at addr 78. Then clear 79..157. Cursor row 1, col 0. in_ready low exactly 80 cycles.
- At row 11, send 0x0A → clear addr 0..78, cursor row 0. Then send 0x08 at col 3 → write 0 at addr 2, cursor col 2. Send 0x08 at col 0 → no write. Send 0x00 → no write.
- Send 0x0C mid-line, assert rst halfway through the clear → after release, clear restarts at addr 0 and runs 1000 cycles. Cursor (0,0).

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream console writer: cursor tracking, control codes, and
// ascending zero fills of the shared text/colour RAM for line and screen clears.
module text_console_writer #(
   parameter int unsigned COLS  = 79,
   parameter int unsigned ROWS  = 12,
   parameter int unsigned DEPTH = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_char,
   input  logic [7:0] in_color,
   output logic       wr_en,
   output logic [9:0] wr_addr,
   output logic [7:0] wr_char,
   output logic [7:0] wr_color,
   output logic [6:0] cursor_col,
   output logic [3:0] cursor_row,
   output logic       busy
);

   localparam int unsigned AW = 10;
   localparam int unsigned NW = AW + 1;
   localparam int unsigned CW = 7;
   localparam int unsigned RW = 4;
   localparam int unsigned DW = 8;

   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {
      CLEAR_ALL,
      IDLE,
      CLEAR_LINE
   } state_t;

   state_t          state, state_n;
   logic [NW-1:0]   clr_cnt, clr_cnt_n;
   logic [CW-1:0]   col_n;
   logic [RW-1:0]   row_n;
   logic            wr_en_n;
   logic [AW-1:0]   wr_addr_n;
   logic [DW-1:0]   wr_char_n;
   logic [DW-1:0]   wr_color_n;
   logic            in_ready_n;
   logic            busy_n;

   logic            accept;
   logic [RW-1:0]   next_row;
   logic [AW-1:0]   line_base;
   logic [AW-1:0]   next_base;

   assign accept    = in_valid & in_ready;
   assign next_row  = (cursor_row == LAST_ROW) ? '0 : cursor_row + RW'(1);
   assign line_base = AW'(cursor_row) * AW'(COLS);
   assign next_base = AW'(next_row) * AW'(COLS);

   // State and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= CLEAR_ALL;
         clr_cnt    <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_char    <= '0;
         wr_color   <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b1;
      end else begin
         state      <= state_n;
         clr_cnt    <= clr_cnt_n;
         cursor_col <= col_n;
         cursor_row <= row_n;
         wr_en      <= wr_en_n;
         wr_addr    <= wr_addr_n;
         wr_char    <= wr_char_n;
         wr_color   <= wr_color_n;
         in_ready   <= in_ready_n;
         busy       <= busy_n;
      end
   end

   // Next-state and output decode; a clear that starts on an accept issues its
   // first fill write immediately so the fill occupies the following cycles.
   always_comb begin
      state_n    = state;
      clr_cnt_n  = clr_cnt;
      col_n      = cursor_col;
      row_n      = cursor_row;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_char_n  = wr_char;
      wr_color_n = wr_color;
      in_ready_n = in_ready;
      busy_n     = busy;

      case (state)
         CLEAR_ALL: begin
            if (clr_cnt < NW'(DEPTH)) begin
               wr_en_n    = 1'b1;
               wr_addr_n  = AW'(clr_cnt);
               wr_char_n  = '0;
               wr_color_n = '0;
               clr_cnt_n  = clr_cnt + NW'(1);
            end else begin
               state_n    = IDLE;
               clr_cnt_n  = '0;
               in_ready_n = 1'b1;
               busy_n     = 1'b0;
            end
         end

         CLEAR_LINE: begin
            if (clr_cnt < NW'(COLS)) begin
               wr_en_n    = 1'b1;
               wr_addr_n  = line_base + AW'(clr_cnt);
               wr_char_n  = '0;
               wr_color_n = '0;
               clr_cnt_n  = clr_cnt + NW'(1);
            end else begin
               state_n    = IDLE;
               clr_cnt_n  = '0;
               in_ready_n = 1'b1;
               busy_n     = 1'b0;
            end
         end

         IDLE: begin
            if (accept) begin
               if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                  wr_en_n    = 1'b1;
                  wr_addr_n  = line_base + AW'(cursor_col);
                  wr_char_n  = in_char;
                  wr_color_n = in_color;
                  if (cursor_col == LAST_COL) begin
                     // Character lands first; the new row's fill follows next cycle
                     col_n      = '0;
                     row_n      = next_row;
                     clr_cnt_n  = '0;
                     state_n    = CLEAR_LINE;
                     in_ready_n = 1'b0;
                     busy_n     = 1'b1;
                  end else begin
                     col_n = cursor_col + CW'(1);
                  end
               end else if (in_char == 8'h0A) begin
                  col_n      = '0;
                  row_n      = next_row;
                  wr_en_n    = 1'b1;
                  wr_addr_n  = next_base;
                  wr_char_n  = '0;
                  wr_color_n = '0;
                  clr_cnt_n  = NW'(1);
                  state_n    = CLEAR_LINE;
                  in_ready_n = 1'b0;
                  busy_n     = 1'b1;
               end else if (in_char == 8'h0D) begin
                  col_n = '0;
               end else if (in_char == 8'h08) begin
                  if (cursor_col != '0) begin
                     col_n      = cursor_col - CW'(1);
                     wr_en_n    = 1'b1;
                     wr_addr_n  = line_base + AW'(cursor_col) - AW'(1);
                     wr_char_n  = '0;
                     wr_color_n = '0;
                  end
               end else if (in_char == 8'h0C) begin
                  col_n      = '0;
                  row_n      = '0;
                  wr_en_n    = 1'b1;
                  wr_addr_n  = '0;
                  wr_char_n  = '0;
                  wr_color_n = '0;
                  clr_cnt_n  = NW'(1);
                  state_n    = CLEAR_ALL;
                  in_ready_n = 1'b0;
                  busy_n     = 1'b1;
               end
            end
         end

         default: begin
            state_n = CLEAR_ALL;
         end
      endcase
   end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a cursor model predicts every RAM
// write, and a monitor pops and compares each write the DUT issues.
module tb_text_console_writer;

   localparam int COLS  = 79;
   localparam int ROWS  = 12;
   localparam int DEPTH = 1000;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;
   logic [7:0] in_color;
   logic       wr_en;
   logic [9:0] wr_addr;
   logic [7:0] wr_char;
   logic [7:0] wr_color;
   logic [6:0] cursor_col;
   logic [3:0] cursor_row;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int mcol    = 0;
   int mrow    = 0;
   logic [25:0] exp_q[$];

   text_console_writer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_char    (in_char),
      .in_color   (in_color),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_char    (wr_char),
      .wr_color   (wr_color),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every DUT write must match the oldest predicted write
   always @(negedge clk) begin
      if (rst === 1'b0 && wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_extra", 32'({wr_addr, wr_char, wr_color}), 32'hFFFF_FFFF);
         end else begin
            check("wr", 32'({wr_addr, wr_char, wr_color}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic push_wr(input int a, input logic [7:0] c, input logic [7:0] k);
      exp_q.push_back({10'(a), c, k});
   endtask

   task automatic push_fill(input int base, input int n);
      for (int i = 0; i < n; i++) push_wr(base + i, 8'h00, 8'h00);
   endtask

   task automatic advance();
      mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
      push_fill(mrow * COLS, COLS);
   endtask

   task automatic model(input logic [7:0] c, input logic [7:0] k, output int low, output bit wr);
      low = 0;
      wr  = 1'b0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         push_wr(mrow * COLS + mcol, c, k);
         wr = 1'b1;
         if (mcol == COLS - 1) begin
            mcol = 0;
            advance();
            low = COLS + 1;
         end else begin
            mcol++;
         end
      end else if (c == 8'h0A) begin
         mcol = 0;
         advance();
         wr  = 1'b1;
         low = COLS;
      end else if (c == 8'h0D) begin
         mcol = 0;
      end else if (c == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            push_wr(mrow * COLS + mcol, 8'h00, 8'h00);
            wr = 1'b1;
         end
      end else if (c == 8'h0C) begin
         mcol = 0;
         mrow = 0;
         push_fill(0, DEPTH);
         wr  = 1'b1;
         low = DEPTH;
      end
   endtask

   // Offer a character, wait for the accept, check the write strobe one cycle later
   task automatic drive(input logic [7:0] c, input logic [7:0] k, output int exp_low);
      int n;
      bit exp_wr;
      in_valid = 1'b1;
      in_char  = c;
      in_color = k;
      n = 0;
      while (in_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 32'(in_ready), 32'd1);
      model(c, k, exp_low, exp_wr);
      @(negedge clk);
      in_valid = 1'b0;
      check("wr_n1", 32'(wr_en), 32'(exp_wr));
   endtask

   task automatic check_cursor();
      check("cursor", 32'({cursor_row, cursor_col}), 32'({4'(mrow), 7'(mcol)}));
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] k);
      int el;
      int low;
      drive(c, k, el);
      low = 0;
      while (in_ready !== 1'b1 && low < 3000) begin
         low++;
         @(negedge clk);
      end
      check("ready_low", 32'(low), 32'(el));
      check_cursor();
   endtask

   task automatic do_reset();
      int low;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_outs", 32'({wr_en, in_ready, busy, wr_addr, wr_char, wr_color}),
            32'({1'b0, 1'b0, 1'b1, 10'd0, 8'd0, 8'd0}));
      exp_q.delete();
      mcol = 0;
      mrow = 0;
      check_cursor();
      push_fill(0, DEPTH);
      rst = 1'b0;
      low = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && low < 3000) begin
         low++;
         @(negedge clk);
      end
      check("init_ready_low", 32'(low), 32'(DEPTH));
      check("busy_idle", 32'(busy), 32'd0);
      check_cursor();
   endtask

   initial begin
      int el;
      in_valid = 1'b0;
      in_char  = 8'h00;
      in_color = 8'h00;
      @(negedge clk);
      do_reset();

      send(8'h41, 8'h02);
      send(8'h0D, 8'h00);
      send(8'h48, 8'h01);
      send(8'h49, 8'h03);
      send(8'h0A, 8'h00);
      send(8'h58, 8'h05);

      send(8'h0C, 8'h00);
      for (int i = 0; i < COLS; i++) send(8'(8'h21 + i), 8'(i));

      for (int i = 0; i < 10; i++) send(8'h0A, 8'h00);
      check("row11", 32'(cursor_row), 32'd11);
      send(8'h0A, 8'h00);
      send(8'h61, 8'h01);
      send(8'h62, 8'h02);
      send(8'h63, 8'h07);
      send(8'h08, 8'h00);
      send(8'h0D, 8'h00);
      send(8'h08, 8'h00);
      send(8'h00, 8'h00);
      send(8'h7F, 8'h00);
      send(8'h1B, 8'h00);

      send(8'h51, 8'h02);
      send(8'h52, 8'h02);
      drive(8'h0C, 8'h00, el);
      repeat (500) @(negedge clk);
      check("ff_mid_busy", 32'(busy), 32'd1);
      do_reset();
      send(8'h5A, 8'h01);

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
